serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial adder sequencer: shares one 1-bit full-adder cell across all W
//   bit positions of two W-bit operands, one bit per clock, LSB first.
//   Carry is held in a register between bits.
//   Start/ready/done handshake toward the requester; sits beside the ripple
//   adders as the low-area add path.
// PARAMETERS
//   W      8   operand/result width in bits; legal range W >= 2
//   CNT_W  $clog2(W)   bit-index counter width (derived, not overridden)
// PORTS
//   clk    in   1   single clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   start  in   1   request; accepted only when ready=1
//   a      in   W   operand A, sampled on the accepting edge
//   b      in   W   operand B, sampled on the accepting edge
//   cin    in   1   carry-in, sampled on the accepting edge
//   ready  out  1   1 in IDLE and DONE (a new start can be accepted)
//   busy   out  1   1 in RUN
//   done   out  1   1-cycle pulse: sum/cout valid
//   sum    out  W   result; held stable from done until the next accepted start
//   cout   out  1   final carry-out; held with sum
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset synchronous, active-high.
//   Reset: state=IDLE, cnt=0, carry=0, sum=0, cout=0, done=0, busy=0, ready=1.
//     Reset during RUN aborts the add. No done pulse; partial result discarded.
//   FSM IDLE -> RUN on (start & ready); DONE -> RUN on start, else DONE -> IDLE.
//   Accepting edge E0: latch a, b into shift regs, carry<=cin, cnt<=0, ->RUN.
//   RUN edge Ek (k=1..W): cell inputs {a_sh[0], b_sh[0], carry}.
//     sum_sh <= {s, sum_sh[W-1:1]}; carry <= co; a_sh, b_sh shift right.
//     cnt++ each RUN edge.
//   Edge E_W (cnt==W-1): sum <= final sum_sh, cout <= co, ->DONE.
//   Latency: done is high in the cycle after E_W (W cycles after the accepting edge).
//   start while busy: ignored, no queuing.
//   Input changes after E0 do not affect the result.
//   Back-to-back: start in DONE is accepted on that edge, so done stays a
//     1-cycle pulse. sum/cout keep the old result until the next E_W.
//   Arithmetic: {cout,sum} == a + b + cin, mod 2^(W+1); no other flags.
// CONFIGURATION
//   SERIAL_ADD_SUB_EN defined:
//     - adds port  sub  in  1, sampled at E0
//     - sub=1: b is inverted when latched, carry<=1 (cin ignored),
//       giving {cout,sum} = a + ~b + 1 (cout=1 means no borrow)
//     - sub=0: identical to the add-only build
//   Undefined: no sub port; add only.
// STRUCTURE
//   Package serial_add_pkg: state typedef {IDLE,RUN,DONE} (2-bit enum), default W.
//   Sub-module fa_bit: combinational 1-bit full adder (a,b,ci -> s,co), one
//     instance. The FSM, counter, shift registers and carry register stay in the top.
// TESTING (W=8)
//   1 reset; a=0F b=01 cin=0 start -> done 8 cycles later, sum=10 cout=0; busy=1 8 cycles.
//   2 a=FF b=01 cin=0 -> sum=00 cout=1; a=FF b=FF cin=1 -> sum=FF cout=1.
//   3 start pulse at cycle 3 of RUN and a/b changed -> ignored; the first result is unchanged.
//   4 reset at cycle 4 of RUN -> next cycle IDLE, sum=00 cout=0, no done pulse ever.
//   5 start held high through DONE -> second add runs; done pulses exactly once per add.
//   6 SERIAL_ADD_SUB_EN: a=05 b=07 sub=1 -> sum=FE cout=0; a=07 b=05 sub=1 -> sum=02 cout=1.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
// No logic, no latency, no flow control.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Purpose: 1-bit full adder cell, shared across all bit positions of the serial add.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no flow control at this level.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: bit-serial W-bit adder, one bit per clock LSB first; SERIAL_ADD_SUB_EN adds a subtract mode.
// Latency: done pulses W cycles after the accepting edge; sum/cout held until the next result.
// Backpressure: start is taken only while ready=1; a start during RUN is dropped, never queued.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int W = DEFAULT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int CNT_W = $clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t           state_q;
   state_t           state_d;
   logic [W-1:0]     a_sh;
   logic [W-1:0]     b_sh;
   logic [W-2:0]     sum_sh;
   logic [W-1:0]     sum_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             fa_s;
   logic             fa_co;
   logic             accept;
   logic             last_bit;
   logic [W-1:0]     b_load;
   logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
   // Subtract as a + ~b + 1: invert b at load and force the initial carry.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   fa_bit u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign accept   = start & ready;
   assign last_bit = (cnt == CNT_LAST);
   // Only W-1 partial bits are kept; the final bit comes straight from the cell.
   assign sum_nxt  = {fa_s, sum_sh};

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            ready   = 1'b1;
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
         end else if (state_q == RUN) begin
            a_sh   <= {1'b0, a_sh[W-1:1]};
            b_sh   <= {1'b0, b_sh[W-1:1]};
            sum_sh <= sum_nxt[W-1:1];
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
               sum  <= sum_nxt;
               cout <= fa_co;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8): vector table, random adds against
// an arithmetic model, and hand sequences for ignored start, reset abort and back-to-back.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs [7];

   serial_add_ctrl #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the full-width arithmetic result of the requested operation.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mc, input logic ms);
      int unsigned r;
      if (ms) r = int'(ma) + ((1 << W) - 1 - int'(mb)) + 1;
      else    r = int'(ma) + int'(mb) + int'(mc);
      return (W+1)'(r % (1 << (W + 1)));
   endfunction

   task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tc,
                         input logic ts, input logic [W:0] exp, input string name);
      int g = 0;
      int cyc = 0;
      int nbusy = 0;
      while (!ready && g < 4 * W) begin
         step();
         g++;
      end
      a = ta; b = tb_b; cin = tc; sub = ts; start = 1'b1;
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      while (!done && cyc < W + 4) begin
         if (busy) nbusy++;
         step();
         cyc++;
      end
      chk({name, " latency"}, cyc, W);
      chk({name, " busy_cycles"}, nbusy, W);
      chk({name, " result"}, 32'({cout, sum}), 32'(exp));
      step();
      chk({name, " done_pulse"}, 32'(done), 0);
      chk({name, " held"}, 32'({cout, sum}), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc;
      int nd;
      int nd_first;
      int nd_second;
      logic [W:0] res_first;
      logic [W:0] res_second;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;

      vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) step();
      chk("reset ready", 32'(ready), 1);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset result", 32'({cout, sum}), 0);
      reset = 1'b0;
      step();
      chk("idle ready", 32'(ready), 1);

      for (int i = 0; i < 7; i++)
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, {vecs[i].cout, vecs[i].sum},
                $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         do_add(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0), $sformatf("rand%0d", i));
      end

      // start during RUN with new operands must be ignored
      a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 3;
      while (!done && cyc < 3 * W) begin
         step();
         cyc++;
      end
      chk("ignore latency", cyc, W);
      chk("ignore result", 32'({cout, sum}), 32'h010);
      step();
      chk("ignore not_queued", 32'(busy), 0);
      chk("ignore ready", 32'(ready), 1);

      // reset mid-run aborts with no done pulse
      a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort ready", 32'(ready), 1);
      chk("abort busy", 32'(busy), 0);
      chk("abort result", 32'({cout, sum}), 0);
      nd = 0;
      for (int i = 0; i < 2 * W; i++) begin
         step();
         if (done) nd++;
      end
      chk("abort no_done", nd, 0);
      chk("abort result_after", 32'({cout, sum}), 0);

      // start held through DONE: back-to-back adds, one done pulse each
      a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
      step();
      a = 8'h10; b = 8'h20;
      nd = 0; nd_first = 0; nd_second = 0; res_first = '0; res_second = '0;
      for (int i = 1; i <= 2 * W + 4; i++) begin
         step();
         if (i == W + 1) chk("b2b busy_second", 32'(busy), 1);
         if (i == W + 1) chk("b2b held_old", 32'({cout, sum}), 32'h007);
         if (done) begin
            nd++;
            if (nd == 1) begin nd_first = i; res_first = {cout, sum}; end
            if (nd == 2) begin nd_second = i; res_second = {cout, sum}; start = 1'b0; end
         end
      end
      start = 1'b0;
      chk("b2b done_count", nd, 2);
      chk("b2b first_at", nd_first, W);
      chk("b2b second_at", nd_second, 2 * W + 1);
      chk("b2b first_result", 32'(res_first), 32'h007);
      chk("b2b second_result", 32'(res_second), 32'h030);
      chk("b2b idle", 32'(busy), 0);

`ifdef SERIAL_ADD_SUB_EN
      do_add(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, "sub_neg");
      do_add(8'h07, 8'h05, 1'b0, 1'b1, 9'h102, "sub_pos");
      do_add(8'h07, 8'h05, 1'b1, 1'b0, 9'h00D, "sub_off");
      for (int i = 0; i < 10; i++) begin
         ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
         do_add(ra, rb, rc, 1'b1, model(ra, rb, rc, 1'b1), $sformatf("rsub%0d", i));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
